// File: rtl/bus_trace_pkg.sv
// ---------------------------------------------------------------------------
// bus_trace_pkg
//   Shared types and constants for the cart-bus tracer.
//   - mode_t      : which bus directions are traced
//   - state_t     : capture FSM states
//   - trace_rec_t : record layout for the default AW/DW build, as seen on
//                   rd_data. It carries a timestamp field only when
//                   BUS_TRACE_TS_EN is defined.
//   - TS_W / CH_W : timestamp and channel-index field widths
// ---------------------------------------------------------------------------
package bus_trace_pkg;

  localparam int TS_W   = 16;
  localparam int CH_W   = 3;
  localparam int REC_AW = 21;
  localparam int REC_DW = 8;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_RD   = 2'b01,
    MODE_WR   = 2'b10,
    MODE_BOTH = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ACT_RD,
    ACT_WR,
    COMMIT
  } state_t;

  typedef struct packed {
`ifdef BUS_TRACE_TS_EN
    logic [TS_W-1:0]   ts;
`endif
    logic [CH_W-1:0]   ch;
    logic              is_wr;
    logic [REC_AW-1:0] addr;
    logic [REC_DW-1:0] data;
  } trace_rec_t;

  function automatic logic mode_has_rd(input mode_t m);
    return (m == MODE_RD) || (m == MODE_BOTH);
  endfunction

  function automatic logic mode_has_wr(input mode_t m);
    return (m == MODE_WR) || (m == MODE_BOTH);
  endfunction

endpackage

// File: rtl/bus_trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
//   First-word-fall-through synchronous FIFO. rdata shows the head entry
//   whenever the FIFO is not empty and reads as zero when it is empty.
//   A pop on an empty FIFO is ignored. A push while full is dropped unless
//   a pop happens in the same cycle, in which case both take effect.
// Parameters: DEPTH (power of two, >= 2), WIDTH
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, wdata     write request and data
//   pop             consume the head entry
//   rdata           head entry
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags
// ---------------------------------------------------------------------------
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array has no reset; only pointers and count do, and
  // rdata is gated by empty so no stale entry is ever visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bus_trace.sv
// ---------------------------------------------------------------------------
// bus_trace
//   Cart-bus cycle tracer. It runs on the 50 MHz core clock and sniffs the
//   asynchronous CPU bus. Strobes, address and data go through the same
//   SYNC_LEN-stage synchroniser, followed by one more aligned stage that
//   feeds the strobe glitch filters. A read or write cycle is opened by a
//   qualified strobe assert and closed by a qualified release. The cycle's
//   address is then matched against NCH base/mask windows. Matching cycles
//   are pushed into an FWFT FIFO that the MCU/debug side drains.
//
// Optional feature: macro BUS_TRACE_TS_EN adds a 16-bit free-running
//   timestamp. The timestamp is latched on the qualified strobe assert and
//   sits in the MSBs of each record.
//
// Ports:
//   clk, rst_n          50 MHz clock, async active-low reset
//   cpu_addr/cpu_dato   raw CPU address / data
//   cpu_oe_n/cpu_we_n   raw read / write strobes, active low
//   cfg_en, cfg_mode    tracer enable; mode 00 none, 01 rd, 10 wr, 11 both
//   cfg_ch_en           per-channel enable
//   cfg_base/cfg_mask   channel i window at [i*AW +: AW]; mask 1 = compared
//   rd_pop              consume FIFO head
//   rd_valid, rd_data   FIFO not empty, head record
//                       {[ts,] ch, is_wr, addr, data}
//   fifo_cnt            FIFO occupancy
//   ovf, ovf_clr        sticky "record dropped while full", and its clear
//   hit                 one-clock pulse per committed matching cycle
// ---------------------------------------------------------------------------
module bus_trace
  import bus_trace_pkg::*;
#(
  parameter int SYNC_LEN   = 3,
  parameter int FILT_LEN   = 2,
  parameter int NCH        = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = REC_AW,
  parameter int DW         = REC_DW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AW-1:0]                 cpu_addr,
  input  logic [DW-1:0]                 cpu_dato,
  input  logic                          cpu_oe_n,
  input  logic                          cpu_we_n,
  input  logic                          cfg_en,
  input  logic [1:0]                    cfg_mode,
  input  logic [NCH-1:0]                cfg_ch_en,
  input  logic [NCH*AW-1:0]             cfg_base,
  input  logic [NCH*AW-1:0]             cfg_mask,
  input  logic                          rd_pop,
  output logic                          rd_valid,
`ifdef BUS_TRACE_TS_EN
  output logic [TS_W+CH_W+AW+DW:0]      rd_data,
`else
  output logic [CH_W+AW+DW:0]           rd_data,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          hit
);

  localparam int BW    = 2 + AW + DW;
  localparam int REC_W = $bits(rd_data);

  // ---------------------------------------------------------------- sync
  // All bus signals share one chain, so they keep their relative timing.
  logic [SYNC_LEN-1:0][BW-1:0] sync_q;
  logic                        oe_s, we_s;
  logic [AW-1:0]               addr_s;
  logic [DW-1:0]               data_s;

  assign {oe_s, we_s, addr_s, data_s} = sync_q[SYNC_LEN-1];

  // The strobe histories hold active-low samples, with [0] the newest.
  // addr_d/data_d are aligned with history bit [0].
  logic [FILT_LEN:0] oe_hist, we_hist;
  logic [AW-1:0]     addr_d;
  logic [DW-1:0]     data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      oe_hist <= '0;
      we_hist <= '0;
      addr_d  <= '0;
      data_d  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_LEN-2:0], {cpu_oe_n, cpu_we_n, cpu_addr, cpu_dato}};
      oe_hist <= {oe_hist[FILT_LEN-1:0], oe_s};
      we_hist <= {we_hist[FILT_LEN-1:0], we_s};
      addr_d  <= addr_s;
      data_d  <= data_s;
    end
  end

  // A qualified assert needs FILT_LEN low samples preceded by a high one.
  // The chains reset to 0, which reads as "asserted". No spurious cycle can
  // start out of reset until the bus has been seen idle.
  logic oe_rise, we_rise, oe_fall, we_fall;
  assign oe_rise = oe_hist[FILT_LEN] && (oe_hist[FILT_LEN-1:0] == '0);
  assign we_rise = we_hist[FILT_LEN] && (we_hist[FILT_LEN-1:0] == '0);
  assign oe_fall = &oe_hist[FILT_LEN-1:0];
  assign we_fall = &we_hist[FILT_LEN-1:0];

  // ----------------------------------------------------------- timestamp
`ifdef BUS_TRACE_TS_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  // ------------------------------------------------------ channel match
  state_t          state;
  mode_t           mode_q;
  mode_t           mode_cur;
  logic            is_wr_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            hit_any;
  logic [CH_W-1:0] hit_ch;

  assign mode_cur = mode_t'(cfg_mode);

  // Scan from the top down so that the lowest matching index is written last.
  always_comb begin
    // NOTE: default every output first so no path leaves a value held (latch).
    hit_any = 1'b0;
    hit_ch  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cfg_ch_en[i] &&
          (((addr_q ^ cfg_base[i*AW +: AW]) & cfg_mask[i*AW +: AW]) == '0)) begin
        hit_any = 1'b1;
        hit_ch  = CH_W'(i);
      end
    end
  end

  // Disabling the tracer or changing mode throws away any open cycle.
  logic abort;
  assign abort = (state != IDLE) && (!cfg_en || (mode_cur != mode_q));

  // ----------------------------------------------------------------- FSM
  // NOTE: all sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values and the block order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= MODE_NONE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hit     <= 1'b0;
`ifdef BUS_TRACE_TS_EN
      ts_q    <= '0;
`endif
    end else begin
      mode_q <= mode_cur;
      hit    <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            // A simultaneous read and write assert opens a write cycle.
            if (cfg_en && we_rise && mode_has_wr(mode_cur)) begin
              state   <= ACT_WR;
              is_wr_q <= 1'b1;
              addr_q  <= addr_d;
              data_q  <= data_d;
`ifdef BUS_TRACE_TS_EN
              ts_q    <= ts_cnt;
`endif
            end else if (cfg_en && oe_rise && mode_has_rd(mode_cur)) begin
              state   <= ACT_RD;
              is_wr_q <= 1'b0;
              addr_q  <= addr_d;
              data_q  <= data_d;
`ifdef BUS_TRACE_TS_EN
              ts_q    <= ts_cnt;
`endif
            end
          end
          ACT_RD: begin
            if (!oe_hist[0]) data_q <= data_d;
            if (oe_fall)     state  <= COMMIT;
          end
          ACT_WR: begin
            if (!we_hist[0]) data_q <= data_d;
            if (we_fall)     state  <= COMMIT;
          end
          COMMIT: begin
            hit   <= hit_any;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [REC_W-1:0] rec_w;
  logic             push_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

`ifdef BUS_TRACE_TS_EN
  assign rec_w = {ts_q, hit_ch, is_wr_q, addr_q, data_q};
`else
  assign rec_w = {hit_ch, is_wr_q, addr_q, data_q};
`endif

  assign push_req = (state == COMMIT) && !abort && hit_any;
  // A full FIFO that is popped in the same cycle frees a slot for the push.
  assign drop     = push_req && fifo_full && !rd_pop;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata (rec_w),
    .pop   (rd_pop),
    .rdata (rd_data),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_valid = !fifo_empty;

  // A new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule
